onehot_scan_decoder: RTL and testbench

//  Parametrised, registered successor to the team's 3-to-7 one-hot decoder.
//  - Manual mode: decodes a binary select code to one output line, registered.
//  - Scan mode: steps through every channel on a timed dwell, with a blanking
//    gap between channels.
//  - Drives digit/LED multiplex lines; sits between control logic and pins.

---
 rtl/onehot_scan_pkg.sv | 11 +
 rtl/onehot_scan_decoder_if.sv | 15 +
 rtl/onehot_decode.sv | 15 +
 rtl/onehot_scan_decoder.sv | 138 +++++++++++++
 tb/tb_onehot_scan_decoder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/onehot_scan_pkg.sv
// Shared types and constants for the one-hot scan decoder.
package onehot_scan_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control and line bundle between the driving logic and the scan decoder.
interface onehot_scan_decoder_if #(
    parameter int SEL_WIDTH = 3,
    parameter int OUT_WIDTH = 7
);
    logic                 en;
    logic                 mode;
    logic [SEL_WIDTH-1:0] sel;
    logic [OUT_WIDTH-1:0] out;
    logic [SEL_WIDTH-1:0] cur_code;
    logic                 frame_done;

    modport master (output en, mode, sel, input out, cur_code, frame_done);
    modport slave  (input en, mode, sel, output out, cur_code, frame_done);
endinterface

// File: rtl/onehot_decode.sv
// Combinational code-to-one-hot decode; code 0 and out-of-range codes give all zeros.
module onehot_decode #(
    parameter int SEL_WIDTH = 3,
    parameter int OUT_WIDTH = 7
) (
    input  logic [SEL_WIDTH-1:0] code,
    output logic [OUT_WIDTH-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int k = 1; k <= OUT_WIDTH; k++) begin
            if (code == SEL_WIDTH'(k)) onehot[k-1] = 1'b1;
        end
    end
endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with manual select and timed auto-scan with blanking.
module onehot_scan_decoder
    import onehot_scan_pkg::*;
#(
    parameter int SEL_WIDTH    = 3,
    parameter int OUT_WIDTH    = 7,
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_scan_decoder_if.slave  bus
);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [SEL_WIDTH-1:0] MAX_CODE   = SEL_WIDTH'(OUT_WIDTH);
    localparam logic [SEL_WIDTH-1:0] FIRST_CODE = SEL_WIDTH'(1);

    if (OUT_WIDTH > 2**SEL_WIDTH - 1) begin : g_bad_out_width
        initial $error("onehot_scan_decoder: OUT_WIDTH %0d exceeds 2**SEL_WIDTH-1", OUT_WIDTH);
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        initial $error("onehot_scan_decoder: DWELL_CYCLES must be at least 1");
    end

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     dwell_q, dwell_n;
    logic [CNT_W-1:0]     blank_q, blank_n;
    logic [SEL_WIDTH-1:0] scan_q, scan_n;
    logic [SEL_WIDTH-1:0] code_q, code_n;
    logic                 frame_q, frame_n;
    logic [OUT_WIDTH-1:0] onehot_q, onehot_n;
    logic [SEL_WIDTH-1:0] next_scan;

    // scan_q remembers the last lit channel so BLANK knows where to resume
    assign next_scan = (scan_q == MAX_CODE) ? FIRST_CODE : scan_q + FIRST_CODE;

    always_comb begin
        state_n = state_q;
        dwell_n = dwell_q;
        blank_n = blank_q;
        scan_n  = scan_q;
        code_n  = code_q;
        frame_n = 1'b0;
        if (!bus.en) begin
            state_n = ST_IDLE;
            dwell_n = '0;
            blank_n = '0;
            scan_n  = '0;
            code_n  = '0;
        end else if (bus.mode == MODE_MANUAL) begin
            state_n = ST_IDLE;
            dwell_n = '0;
            blank_n = '0;
            scan_n  = '0;
            code_n  = (bus.sel <= MAX_CODE) ? bus.sel : '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n = ST_ACTIVE;
                    dwell_n = '0;
                    blank_n = '0;
                    scan_n  = FIRST_CODE;
                    code_n  = FIRST_CODE;
                end
                ST_ACTIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_n = '0;
                        frame_n = (scan_q == MAX_CODE);
                        if (BLANK_CYCLES > 0) begin
                            state_n = ST_BLANK;
                            blank_n = '0;
                            code_n  = '0;
                        end else begin
                            scan_n = next_scan;
                            code_n = next_scan;
                        end
                    end else begin
                        dwell_n = dwell_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_n = ST_ACTIVE;
                        blank_n = '0;
                        scan_n  = next_scan;
                        code_n  = next_scan;
                    end else begin
                        blank_n = blank_q + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    dwell_n = '0;
                    blank_n = '0;
                    scan_n  = '0;
                    code_n  = '0;
                end
            endcase
        end
    end

    // decode the next code so the lines are registered alongside cur_code
    onehot_decode #(
        .SEL_WIDTH (SEL_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_decode (
        .code   (code_n),
        .onehot (onehot_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            blank_q  <= '0;
            scan_q   <= '0;
            code_q   <= '0;
            frame_q  <= 1'b0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_n;
            dwell_q  <= dwell_n;
            blank_q  <= blank_n;
            scan_q   <= scan_n;
            code_q   <= code_n;
            frame_q  <= frame_n;
            onehot_q <= onehot_n;
        end
    end

    assign bus.out        = ACTIVE_LOW ? ~onehot_q : onehot_q;
    assign bus.cur_code   = code_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Bench for onehot_scan_decoder: two builds (default, and active-low without blanking) against a timing model.
module tb_onehot_scan_decoder;
    import onehot_scan_pkg::*;

    localparam int SW = 3;
    localparam int OW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic mode = MODE_SCAN;
    logic [SW-1:0] sel = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_scan_decoder_if #(.SEL_WIDTH(SW), .OUT_WIDTH(OW)) bus_a ();
    onehot_scan_decoder_if #(.SEL_WIDTH(SW), .OUT_WIDTH(OW)) bus_b ();

    assign bus_a.en = en;
    assign bus_a.mode = mode;
    assign bus_a.sel = sel;
    assign bus_b.en = en;
    assign bus_b.mode = mode;
    assign bus_b.sel = sel;

    onehot_scan_decoder #(
        .SEL_WIDTH(SW), .OUT_WIDTH(OW), .DWELL_CYCLES(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

    onehot_scan_decoder #(
        .SEL_WIDTH(SW), .OUT_WIDTH(OW), .DWELL_CYCLES(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: kind 0 = dark, 1 = manual decode, 2 = scanning for t cycles since entry
    int kind = 0;
    int man_code = 0;
    int t = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind = 0;
            man_code = 0;
            t = 0;
        end else if (!en) begin
            kind = 0;
        end else if (mode == MODE_MANUAL) begin
            kind = 1;
            man_code = (int'(sel) >= 1 && int'(sel) <= OW) ? int'(sel) : 0;
        end else if (kind != 2) begin
            kind = 2;
            t = 0;
        end else begin
            t++;
        end
    end

    function automatic int exp_code(input int dwell, input int blank);
        int p;
        if (kind == 1) return man_code;
        if (kind != 2) return 0;
        p = dwell + blank;
        if ((t % p) >= dwell) return 0;
        return (t / p) % OW + 1;
    endfunction

    function automatic int exp_frame(input int dwell, input int blank);
        int p;
        p = dwell + blank;
        if (kind != 2 || t < dwell) return 0;
        return (((t - dwell) % (p * OW)) == p * (OW - 1)) ? 1 : 0;
    endfunction

    function automatic logic [OW-1:0] exp_out(input int code, input bit al);
        logic [OW-1:0] v;
        v = '0;
        if (code > 0) v[code-1] = 1'b1;
        return al ? ~v : v;
    endfunction

    always @(negedge clk) begin : cmp
        int ca, cb;
        ca = exp_code(4, 1);
        cb = exp_code(4, 0);
        check("a_code", 32'(bus_a.cur_code), 32'(ca));
        check("a_out", 32'(bus_a.out), 32'(exp_out(ca, 1'b0)));
        check("a_frame", 32'(bus_a.frame_done), 32'(exp_frame(4, 1)));
        check("b_code", 32'(bus_b.cur_code), 32'(cb));
        check("b_out", 32'(bus_b.out), 32'(exp_out(cb, 1'b1)));
        check("b_frame", 32'(bus_b.frame_done), 32'(exp_frame(4, 0)));
    end

    initial begin : stim
        int first_k, pulses, gaps_b, wrap_code;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // async reset in the middle of a scan
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_out", 32'(bus_a.out), 32'h00);
        check("rst_a_code", 32'(bus_a.cur_code), 32'd0);
        check("rst_b_out", 32'(bus_b.out), 32'h7f);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("b_idle_out", 32'(bus_b.out), 32'h7f);
        @(negedge clk);
        check("b_code1_out", 32'(bus_b.out), 32'h7e);
        check("a_code1_out", 32'(bus_a.out), 32'h01);

        // manual sweep
        mode = MODE_MANUAL;
        for (int s = 0; s <= 7; s++) begin
            sel = SW'(s);
            @(negedge clk);
            check("man_out", 32'(bus_a.out), (s == 0) ? 32'd0 : (32'd1 << (s - 1)));
            check("man_code", 32'(bus_a.cur_code), 32'(s));
        end

        // 40-cycle scan from manual
        sel = '0;
        mode = MODE_SCAN;
        first_k = -1;
        pulses = 0;
        gaps_b = 0;
        wrap_code = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus_a.frame_done) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (bus_b.out == 7'h7f) gaps_b++;
            if (k == 37) wrap_code = int'(bus_a.cur_code);
        end
        check("frame_first_cycle", 32'(first_k), 32'd35);
        check("frame_pulses", 32'(pulses), 32'd1);
        check("b_no_gap", 32'(gaps_b), 32'd0);
        check("wrap_code", 32'(wrap_code), 32'd1);

        // scan -> manual during code 3, then back to scan
        for (int i = 0; i < 100 && bus_a.cur_code != 3'd3; i++) @(negedge clk);
        check("reach_code3", 32'(bus_a.cur_code), 32'd3);
        sel = 3'd5;
        mode = MODE_MANUAL;
        @(negedge clk);
        check("switch_manual_out", 32'(bus_a.out), 32'b0010000);
        mode = MODE_SCAN;
        @(negedge clk);
        check("rescan_code", 32'(bus_a.cur_code), 32'd1);

        // en low mid-dwell, then back on
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_a_out", 32'(bus_a.out), 32'h00);
        check("en_off_b_out", 32'(bus_b.out), 32'h7f);
        en = 1'b1;
        @(negedge clk);
        check("en_on_code", 32'(bus_a.cur_code), 32'd1);

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) mode = ~mode;
            en = ($urandom_range(0, 49) != 0);
            sel = SW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
